// File: rtl/lbm_pkg.sv
// lbm_pkg: D2Q9 direction encoding, streaming offset tables and composer FSM states.
package lbm_pkg;
  typedef enum logic [3:0] {
    DIR_REST, DIR_E, DIR_N, DIR_W, DIR_S, DIR_NE, DIR_NW, DIR_SW, DIR_SE
  } dir_e;
  typedef enum logic [1:0] {IDLE, OFFSET, MUL, DONE} state_e;
  // Padded to 16 entries so any 4-bit dir indexes safely; codes 9..15 are rejected separately.
  localparam int DROW [16] = '{0, 0, -1, 0, 1, -1, -1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  localparam int DCOL [16] = '{0, 1, 0, -1, 0, 1, -1, -1, 1, 0, 0, 0, 0, 0, 0, 0};
endpackage

// File: rtl/const_shift_add_mult.sv
// const_shift_add_mult: iterative operand*GRID_DIM, one operand bit per cycle, LSB first.
module const_shift_add_mult #(
  parameter int GRID_DIM = 16,
  parameter int COORD_WIDTH = $clog2(GRID_DIM),
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM * GRID_DIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COORD_WIDTH-1:0]   operand,
  output logic [ADDRESS_WIDTH-1:0] product,
  output logic                     done
);
  logic [COORD_WIDTH-1:0] mplr;
  logic [ADDRESS_WIDTH-1:0] mcand, acc;
  logic [COORD_WIDTH:0] cnt;
  logic run;
  assign done = run && cnt == (COORD_WIDTH + 1)'(COORD_WIDTH - 1);
  assign product = acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mplr <= '0;
      mcand <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      acc <= '0;
      mplr <= operand;
      mcand <= ADDRESS_WIDTH'(GRID_DIM);
    end else if (run) begin
      acc <= mplr[0] ? acc + mcand : acc;
      mplr <= mplr >> 1;
      mcand <= mcand << 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
  end
endmodule

// File: rtl/address_composer.sv
// address_composer: (row, column, D2Q9 dir) -> linear target address; LBM_PERIODIC_WRAP_EN selects periodic wrap.
module address_composer
  import lbm_pkg::*;
#(
  parameter int GRID_DIM = 16,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM * GRID_DIM),
  parameter int COORD_WIDTH = $clog2(GRID_DIM)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [COORD_WIDTH-1:0]   row,
  input  logic [COORD_WIDTH-1:0]   column,
  input  logic [3:0]               dir,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     busy,
  output logic                     valid,
  output logic                     oob
);
  state_e state, state_n;
  logic [COORD_WIDTH-1:0] row_q, col_q, row_t, col_t, col_tq;
  logic [3:0] dir_q;
  logic [ADDRESS_WIDTH-1:0] product, sum, addr_r;
  logic accept, bad, oob_t, oob_q, oob_r, mul_done;
  int tr, tc;
  assign busy = state != IDLE;
  assign valid = state == DONE;
  assign accept = start && !busy;
  assign sum = oob_q ? '0 : product + ADDRESS_WIDTH'(col_tq);
  assign address = valid ? sum : addr_r;
  assign oob = valid ? oob_q : oob_r;
  assign row_t = COORD_WIDTH'(tr);
  assign col_t = COORD_WIDTH'(tc);
  always_comb begin
    tr = int'(row_q) + DROW[dir_q];
    tc = int'(col_q) + DCOL[dir_q];
    bad = int'(row_q) >= GRID_DIM || int'(col_q) >= GRID_DIM || dir_q > 4'd8;
`ifdef LBM_PERIODIC_WRAP_EN
    tr = tr < 0 ? tr + GRID_DIM : tr >= GRID_DIM ? tr - GRID_DIM : tr;
    tc = tc < 0 ? tc + GRID_DIM : tc >= GRID_DIM ? tc - GRID_DIM : tc;
    oob_t = bad;
`else
    oob_t = bad || tr < 0 || tr >= GRID_DIM || tc < 0 || tc >= GRID_DIM;
`endif
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (accept ? OFFSET : IDLE) :
              state == OFFSET ? MUL :
              state == MUL    ? (mul_done ? DONE : MUL) : IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      row_q <= '0;
      col_q <= '0;
      dir_q <= '0;
      col_tq <= '0;
      oob_q <= 1'b0;
      oob_r <= 1'b0;
      addr_r <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        row_q <= row;
        col_q <= column;
        dir_q <= dir;
      end
      if (state == OFFSET) begin
        col_tq <= col_t;
        oob_q <= oob_t;
      end
      if (state == DONE) begin
        addr_r <= sum;
        oob_r <= oob_q;
      end
    end
  end
  const_shift_add_mult #(
    .GRID_DIM(GRID_DIM), .COORD_WIDTH(COORD_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_mult (
    .clk(Clk), .rst(Reset), .start(state == OFFSET), .operand(row_t),
    .product(product), .done(mul_done)
  );
endmodule

// File: tb/tb_address_composer.sv
// tb_address_composer: directed checks of address_composer at GRID_DIM=16 and GRID_DIM=10.
module tb_address_composer;
`ifdef LBM_PERIODIC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic s16 = 1'b0, s10 = 1'b0;
  logic [3:0] r16 = '0, c16 = '0, d16 = '0, r10 = '0, c10 = '0, d10 = '0;
  logic [7:0] a16;
  logic [6:0] a10;
  logic b16, v16, o16, b10, v10, o10;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  address_composer dut16 (
    .Clk(clk), .Reset(rst), .start(s16), .row(r16), .column(c16), .dir(d16),
    .address(a16), .busy(b16), .valid(v16), .oob(o16)
  );
  address_composer #(.GRID_DIM(10)) dut10 (
    .Clk(clk), .Reset(rst), .start(s10), .row(r10), .column(c10), .dir(d10),
    .address(a10), .busy(b10), .valid(v10), .oob(o10)
  );

  task automatic run_req(input bit g, input int r, input int c, input int d,
                         output int lat, output logic [7:0] a, output logic o);
    @(negedge clk);
    if (g) begin s10 = 1'b1; r10 = 4'(r); c10 = 4'(c); d10 = 4'(d); end
    else begin s16 = 1'b1; r16 = 4'(r); c16 = 4'(c); d16 = 4'(d); end
    @(negedge clk);
    s16 = 1'b0;
    s10 = 1'b0;
    lat = 1;
    while (!(g ? v10 : v16) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) lat = 99;
    a = g ? {1'b0, a10} : a16;
    o = g ? o10 : o16;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 4;
    if (a16 !== 8'd0) begin miscompares++; $display("FAIL reset_address got %0d want 0", a16); end
    if (b16 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", b16); end
    if (v16 !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", v16); end
    if (o16 !== 1'b0) begin miscompares++; $display("FAIL reset_oob got %b want 0", o16); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] a;
    logic o;
    run_req(1'b0, 3, 5, 0, lat, a, o);
    vectors += 4;
    if (lat !== 6) begin miscompares++; $display("FAIL basic_latency got %0d want 6", lat); end
    if (a !== 8'd53) begin miscompares++; $display("FAIL basic_address got %0d want 53", a); end
    if (o !== 1'b0) begin miscompares++; $display("FAIL basic_oob got %b want 0", o); end
    if (b16 !== 1'b1) begin miscompares++; $display("FAIL basic_busy_in_valid got %b want 1", b16); end
    @(negedge clk);
    vectors += 3;
    if (v16 !== 1'b0) begin miscompares++; $display("FAIL basic_valid_pulse got %b want 0", v16); end
    if (b16 !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after got %b want 0", b16); end
    if (a16 !== 8'd53) begin miscompares++; $display("FAIL basic_address_hold got %0d want 53", a16); end
  endtask

  task automatic test_directions();
    int exp_a [9] = '{85, 86, 69, 84, 101, 70, 68, 100, 102};
    int lat;
    logic [7:0] a;
    logic o;
    for (int i = 0; i < 9; i++) begin
      run_req(1'b0, 5, 5, i, lat, a, o);
      vectors += 2;
      if (a !== 8'(exp_a[i]) || o !== 1'b0) begin
        miscompares++;
        $display("FAIL dir%0d_address got %0d/oob %b want %0d/oob 0", i, a, o, exp_a[i]);
      end
      if (lat !== 6) begin miscompares++; $display("FAIL dir%0d_latency got %0d want 6", i, lat); end
    end
  endtask

  task automatic test_boundary();
    int rr [4] = '{2, 0, 15, 3};
    int cc [4] = '{15, 0, 15, 3};
    int dd [4] = '{1, 6, 8, 9};
    int wa [4] = '{32, 255, 0, 0};
    bit wo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    logic [7:0] a, ea;
    logic o, eo;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, rr[i], cc[i], dd[i], lat, a, o);
      eo = WRAP ? wo[i] : 1'b1;
      ea = eo ? 8'd0 : 8'(wa[i]);
      vectors += 3;
      if (a !== ea) begin miscompares++; $display("FAIL edge%0d_address got %0d want %0d", i, a, ea); end
      if (o !== eo) begin miscompares++; $display("FAIL edge%0d_oob got %b want %b", i, o, eo); end
      if (lat !== 6) begin miscompares++; $display("FAIL edge%0d_latency got %0d want 6", i, lat); end
    end
  endtask

  task automatic test_grid10();
    int rr [4] = '{7, 10, 9, 0};
    int cc [4] = '{3, 2, 9, 5};
    int dd [4] = '{4, 0, 8, 2};
    int wa [4] = '{83, 0, 0, 95};
    bit wo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit nw [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    logic [7:0] a, ea;
    logic o, eo;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b1, rr[i], cc[i], dd[i], lat, a, o);
      eo = WRAP ? wo[i] : nw[i];
      ea = eo ? 8'd0 : 8'(wa[i]);
      vectors += 3;
      if (a !== ea) begin miscompares++; $display("FAIL g10_%0d_address got %0d want %0d", i, a, ea); end
      if (o !== eo) begin miscompares++; $display("FAIL g10_%0d_oob got %b want %b", i, o, eo); end
      if (lat !== 6) begin miscompares++; $display("FAIL g10_%0d_latency got %0d want 6", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic ev;
    @(negedge clk);
    s16 = 1'b1; r16 = 4'd1; c16 = 4'd1; d16 = 4'd0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      ev = (k % 7) == 6;
      vectors++;
      if (v16 !== ev) begin miscompares++; $display("FAIL b2b_valid_c%0d got %b want %b", k, v16, ev); end
      if (ev) begin
        vectors++;
        if (a16 !== 8'd17) begin miscompares++; $display("FAIL b2b_address_c%0d got %0d want 17", k, a16); end
      end
    end
    s16 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    logic ev;
    @(negedge clk);
    s16 = 1'b1; r16 = 4'd2; c16 = 4'd0; d16 = 4'd0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      ev = k == 6 || k == 13;
      vectors++;
      if (v16 !== ev) begin miscompares++; $display("FAIL ign_valid_c%0d got %b want %b", k, v16, ev); end
      if (k == 6) begin
        vectors++;
        if (a16 !== 8'd32) begin miscompares++; $display("FAIL ign_first_address got %0d want 32", a16); end
      end
      if (k == 7) begin
        vectors++;
        if (b16 !== 1'b0) begin miscompares++; $display("FAIL ign_busy_after_valid got %b want 0", b16); end
      end
      if (k == 13) begin
        vectors++;
        if (a16 !== 8'd68) begin miscompares++; $display("FAIL ign_next_address got %0d want 68", a16); end
      end
      s16 = k == 2 || k == 6 || k == 7;
      r16 = k == 7 ? 4'd4 : 4'd9;
      c16 = k == 7 ? 4'd4 : 4'd9;
    end
    s16 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int seen, lat;
    logic [7:0] a;
    logic o;
    @(negedge clk);
    s16 = 1'b1; r16 = 4'd3; c16 = 4'd5; d16 = 4'd0;
    @(negedge clk);
    s16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors += 3;
    if (a16 !== 8'd0) begin miscompares++; $display("FAIL abort_address got %0d want 0", a16); end
    if (b16 !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", b16); end
    if (o16 !== 1'b0) begin miscompares++; $display("FAIL abort_oob got %b want 0", o16); end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (v16) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL abort_no_valid got %0d pulses want 0", seen); end
    rst = 1'b1; s16 = 1'b1;
    @(negedge clk);
    rst = 1'b0; s16 = 1'b0;
    @(negedge clk);
    vectors++;
    if (b16 !== 1'b0) begin miscompares++; $display("FAIL reset_beats_start busy got %b want 0", b16); end
    run_req(1'b0, 4, 4, 0, lat, a, o);
    vectors += 2;
    if (a !== 8'd68 || o !== 1'b0) begin miscompares++; $display("FAIL post_reset_address got %0d/oob %b want 68/oob 0", a, o); end
    if (lat !== 6) begin miscompares++; $display("FAIL post_reset_latency got %0d want 6", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directions();
    test_boundary();
    test_grid10();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
